// File: rtl/reactor_kinetics_stepper.sv
// reactor_kinetics_stepper: timestep master and prompt-neutron integrator.
// Issues new_timestep pulses to the precursor trackers and holds the shared
// neutron_flux bus. Two cycles after each pulse it samples precursor_neutrons
// and reactivity_coef, then advances the flux by one explicit-Euler step:
//   flux' = clamp(flux + (coef*flux >>> COEF_FRAC_BITS) + (precursor >> SRC_SHIFT))
// Optional feature macro: KINETICS_SCRAM_EN (adds scram_in and SCRAM_COEF).
//
// Ports:
//   clk_in             : clock
//   rst_in             : synchronous active-high reset
//   scram_in           : scram request, sticky until reset (macro builds only)
//   step_en            : enables the step period counter
//   reactivity_coef    : signed Q(24-COEF_FRAC_BITS).COEF_FRAC_BITS coefficient
//   precursor_neutrons : unsigned precursor tracker result
//   new_timestep       : one-cycle pulse to the trackers
//   neutron_flux       : registered unsigned flux bus
//   step_done          : one-cycle pulse when the new flux is visible
//   step_count         : completed steps, wraps modulo 2^32
//   flux_sat           : sticky clamp flag

`timescale 1ns/1ps

module reactor_kinetics_stepper #(
    parameter int          CYCLES_PER_STEP = 16,
    parameter int          COEF_FRAC_BITS  = 20,
    parameter int          SRC_SHIFT       = 3,
    parameter logic [50:0] INIT_FLUX       = 51'd1 << 47
`ifdef KINETICS_SCRAM_EN
    ,
    parameter logic signed [23:0] SCRAM_COEF = -24'sd524288
`endif
) (
    input  logic        clk_in,
    input  logic        rst_in,
`ifdef KINETICS_SCRAM_EN
    input  logic        scram_in,
`endif
    input  logic        step_en,
    input  logic [23:0] reactivity_coef,
    input  logic [63:0] precursor_neutrons,
    output logic        new_timestep,
    output logic [50:0] neutron_flux,
    output logic        step_done,
    output logic [31:0] step_count,
    output logic        flux_sat
);

    localparam int          CW       = $clog2(CYCLES_PER_STEP);
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_STEP - 1);
    localparam logic [50:0] FLUX_MAX = {51{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_ADD    = 3'd4
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic                r_new_ts;
    logic                r_done;
    logic [50:0]         r_flux;
    logic [31:0]         r_count;
    logic                r_sat;
    logic signed [75:0]  r_prod;
    logic [63:0]         r_prec;
`ifdef KINETICS_SCRAM_EN
    logic                r_scram;
`endif

    logic                w_wrap;
    logic signed [23:0]  w_coef;
    logic signed [75:0]  w_coef_x;
    logic signed [75:0]  w_flux_x;
    logic signed [75:0]  w_prod;
    logic signed [75:0]  w_prod_sh;
    logic [63:0]         w_src;
    logic [76:0]         w_sum;
    logic                w_neg;
    logic                w_over;

    assign w_wrap = step_en && (r_cnt == CNT_LAST);

`ifdef KINETICS_SCRAM_EN
    assign w_coef = r_scram ? SCRAM_COEF : $signed(reactivity_coef);
`else
    assign w_coef = $signed(reactivity_coef);
`endif

    // Both operands widened to the full product width so the signed
    // multiply is exact without relying on context extension.
    assign w_coef_x = {{52{w_coef[23]}}, w_coef};
    assign w_flux_x = $signed({25'd0, r_flux});
    assign w_prod   = w_coef_x * w_flux_x;

    assign w_prod_sh = r_prod >>> COEF_FRAC_BITS;
    assign w_src     = r_prec >> SRC_SHIFT;

    // 77-bit two's complement sum; bit 76 is the sign.
    assign w_sum  = {26'd0, r_flux}
                  + {w_prod_sh[75], w_prod_sh}
                  + {13'd0, w_src};
    assign w_neg  = w_sum[76];
    assign w_over = |w_sum[75:51];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_new_ts <= 1'b0;
            r_done   <= 1'b0;
            r_flux   <= INIT_FLUX;
            r_count  <= '0;
            r_sat    <= 1'b0;
            r_prod   <= '0;
            r_prec   <= '0;
`ifdef KINETICS_SCRAM_EN
            r_scram  <= 1'b0;
`endif
        end else begin
            r_new_ts <= 1'b0;
            r_done   <= 1'b0;

            if (step_en) begin
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            end

`ifdef KINETICS_SCRAM_EN
            if (scram_in) begin
                r_scram <= 1'b1;
            end
`endif

            unique case (r_state)
                S_IDLE: begin
                    if (w_wrap) begin
                        r_state  <= S_ISSUE;
                        r_new_ts <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    r_prod  <= w_prod;
                    r_prec  <= precursor_neutrons;
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    // Flux bus only moves here, keeping it stable
                    // across both tracker update edges.
                    if (w_neg) begin
                        r_flux <= '0;
                        r_sat  <= 1'b1;
                    end else if (w_over) begin
                        r_flux <= FLUX_MAX;
                        r_sat  <= 1'b1;
                    end else begin
                        r_flux <= w_sum[50:0];
                    end
                    r_done  <= 1'b1;
                    r_count <= r_count + 32'd1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign new_timestep = r_new_ts;
    assign neutron_flux = r_flux;
    assign step_done    = r_done;
    assign step_count   = r_count;
    assign flux_sat     = r_sat;

endmodule

// File: tb/tb_reactor_kinetics_stepper.sv
// tb_reactor_kinetics_stepper: directed bench for reactor_kinetics_stepper.
// Scoreboard of expected step results, popped on each step_done.

`timescale 1ns/1ps

module tb_reactor_kinetics_stepper;

    localparam logic [50:0] F_INIT = 51'd1 << 47;
    localparam logic [50:0] F_MAX  = {51{1'b1}};

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        step_en = 1'b0;
    logic [23:0] reactivity_coef = '0;
    logic [63:0] precursor_neutrons = '0;
`ifdef KINETICS_SCRAM_EN
    logic        scram_in = 1'b0;
`endif
    logic        new_timestep;
    logic [50:0] neutron_flux;
    logic        step_done;
    logic [31:0] step_count;
    logic        flux_sat;

    always #5 clk_in = ~clk_in;

    reactor_kinetics_stepper dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
`ifdef KINETICS_SCRAM_EN
        .scram_in           (scram_in),
`endif
        .step_en            (step_en),
        .reactivity_coef    (reactivity_coef),
        .precursor_neutrons (precursor_neutrons),
        .new_timestep       (new_timestep),
        .neutron_flux       (neutron_flux),
        .step_done          (step_done),
        .step_count         (step_count),
        .flux_sat           (flux_sat)
    );

    typedef struct packed {
        logic [50:0] flux;
        logic        sat;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [50:0] f_t;
    bit          hold_chk = 0;
    logic [50:0] m_flux;
    logic        m_sat;
    logic [31:0] m_cnt;

    // cyc == k while sampling (negedge) inside post-reset cycle k
    always @(posedge clk_in) cyc = rst_in ? 0 : cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (hold_chk) chk("flux_hold_T1", 64'(neutron_flux), 64'(f_t));
        hold_chk = 0;
        if (new_timestep) begin
            f_t = neutron_flux;
            hold_chk = 1;
        end
        if (step_done) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_done", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("sb_flux", 64'(neutron_flux), 64'(e.flux));
                chk("sb_sat", 64'(flux_sat), 64'(e.sat));
                chk("sb_count", 64'(step_count), 64'(e.cnt));
            end
        end
    end

    function automatic void model(input logic signed [23:0] c,
                                  input logic [63:0] p);
        logic signed [127:0] f, pr, s;
        f  = $signed({77'd0, m_flux});
        pr = $signed({{104{c[23]}}, c}) * f;
        s  = f + (pr >>> 20) + $signed({64'd0, p >> 3});
        if (s < 0) begin
            m_flux = '0;
            m_sat  = 1'b1;
        end else if (s > $signed({77'd0, F_MAX})) begin
            m_flux = F_MAX;
            m_sat  = 1'b1;
        end else begin
            m_flux = s[50:0];
        end
        m_cnt = m_cnt + 32'd1;
    endfunction

    task automatic push_model(input logic [23:0] c, input logic [63:0] p);
        model(c, p);
        sb.push_back('{flux: m_flux, sat: m_sat, cnt: m_cnt});
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!step_done && n < budget);
        chk("done_timeout", 64'(step_done), 64'd1);
    endtask

    task automatic do_step(input logic [23:0] c, input logic [63:0] p);
        reactivity_coef    = c;
        precursor_neutrons = p;
        push_model(c, p);
        wait_done(40);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in  = 1'b1;
        step_en = 1'b0;
`ifdef KINETICS_SCRAM_EN
        scram_in = 1'b0;
`endif
        @(negedge clk_in);
        rst_in  = 1'b0;
        step_en = 1'b1;
        m_flux  = F_INIT;
        m_sat   = 1'b0;
        m_cnt   = '0;
        chk("rst_nt", 64'(new_timestep), 64'd0);
        chk("rst_flux", 64'(neutron_flux), 64'(F_INIT));
        chk("rst_done", 64'(step_done), 64'd0);
        chk("rst_count", 64'(step_count), 64'd0);
        chk("rst_sat", 64'(flux_sat), 64'd0);
        chk("rst_state", 64'(dut.r_state), 64'd0);
        chk("rst_cyc", 64'(cyc), 64'd0);
    endtask

    initial begin
        logic [23:0] c_eq, c_up, c_dn, c_rnd;
        logic [63:0] p_eq, p_rnd;
        bit          nt_exp, sd_exp;
        c_eq = -24'sd1048576;
        c_up = 24'sd1048576;
        c_dn = -24'sd2097152;
        p_eq = 64'd1 << 50;

        // cadence with step_en held high
        do_reset();
        reactivity_coef    = c_eq;
        precursor_neutrons = p_eq;
        for (int i = 0; i < 3; i++) push_model(c_eq, p_eq);
        for (int c = 0; c < 56; c++) begin
            if (c > 0) @(negedge clk_in);
            nt_exp = (c == 16 || c == 32 || c == 48);
            sd_exp = (c == 20 || c == 36 || c == 52);
            chk($sformatf("cad_nt_c%0d", c), 64'(new_timestep), 64'(nt_exp));
            chk($sformatf("cad_sd_c%0d", c), 64'(step_done), 64'(sd_exp));
        end

        // step_en dropped in cycle 17
        do_reset();
        push_model(c_eq, p_eq);
        for (int c = 0; c < 46; c++) begin
            if (c > 0) @(negedge clk_in);
            if (c == 17) step_en = 1'b0;
            nt_exp = (c == 16);
            sd_exp = (c == 20);
            chk($sformatf("en_nt_c%0d", c), 64'(new_timestep), 64'(nt_exp));
            chk($sformatf("en_sd_c%0d", c), 64'(step_done), 64'(sd_exp));
        end

        // equilibrium for 10 steps
        do_reset();
        for (int i = 0; i < 10; i++) do_step(c_eq, p_eq);
        @(negedge clk_in);
        chk("eq_flux", 64'(neutron_flux), 64'(F_INIT));
        chk("eq_sat", 64'(flux_sat), 64'd0);
        chk("eq_count", 64'(step_count), 64'd10);

        // growth up to the upper clamp
        do_reset();
        for (int i = 0; i < 3; i++) do_step(c_up, 64'd0);
        chk("grow_flux3", 64'(neutron_flux), 64'd1 << 50);
        chk("grow_sat3", 64'(flux_sat), 64'd0);
        do_step(c_up, 64'd0);
        chk("grow_flux4", 64'(neutron_flux), 64'(F_MAX));
        chk("grow_sat4", 64'(flux_sat), 64'd1);

        // lower clamp, then recovery from the source term
        do_reset();
        do_step(c_dn, 64'd0);
        chk("low_flux1", 64'(neutron_flux), 64'd0);
        chk("low_sat1", 64'(flux_sat), 64'd1);
        do_step(24'd0, 64'd1024);
        chk("low_flux2", 64'(neutron_flux), 64'd128);
        chk("low_sat2", 64'(flux_sat), 64'd1);

        // mixed coefficients and source terms against the model
        do_reset();
        for (int i = 0; i < 6; i++) begin
            c_rnd = 24'($urandom_range(0, 2097152)) - 24'd1048576;
            p_rnd = {16'd0, 16'($urandom), $urandom};
            do_step(c_rnd, p_rnd);
        end

        // reset asserted in T+2 aborts the step
        do_reset();
        do_step(c_up, 64'd0);
        begin
            int n = 0;
            do begin
                @(negedge clk_in);
                n++;
            end while (!new_timestep && n < 40);
            chk("rst_wait_nt", 64'(new_timestep), 64'd1);
        end
        @(negedge clk_in);
        @(negedge clk_in);
        chk("abort_state_T2", 64'(dut.r_state), 64'd3);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("abort_flux", 64'(neutron_flux), 64'(F_INIT));
        chk("abort_state", 64'(dut.r_state), 64'd0);
        chk("abort_done_T3", 64'(step_done), 64'd0);
        chk("abort_count", 64'(step_count), 64'd0);
        @(negedge clk_in);
        chk("abort_done_T4", 64'(step_done), 64'd0);

`ifdef KINETICS_SCRAM_EN
        // scram latch forces the scram coefficient and persists
        do_reset();
        @(negedge clk_in);
        scram_in = 1'b1;
        @(negedge clk_in);
        scram_in = 1'b0;
        reactivity_coef    = '0;
        precursor_neutrons = '0;
        push_model(-24'sd524288, 64'd0);
        wait_done(40);
        chk("scram_flux1", 64'(neutron_flux), 64'd1 << 46);
        push_model(-24'sd524288, 64'd0);
        wait_done(40);
        chk("scram_flux2", 64'(neutron_flux), 64'd1 << 45);
`endif

        @(negedge clk_in);
        @(negedge clk_in);
        chk("sb_left", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reactor_kinetics_stepper.md
# reactor_kinetics_stepper

Timestep master and prompt-neutron integrator for the reactor simulation. It issues `new_timestep` pulses to the delayed-neutron precursor group trackers and drives the shared `neutron_flux` bus. It collects the group's `precursor_neutrons` result after the tracker's two-cycle update, then advances the flux by one explicit-Euler step with a signed reactivity coefficient. It is the producer side of the tracker interface: it drives flux and timestep and consumes precursor output.

## Interface
Parameters:
- `CYCLES_PER_STEP`, 16: clock cycles between `new_timestep` pulses; legal range ≥ 5.
- `COEF_FRAC_BITS`, 20: fractional bits of `reactivity_coef`.
- `SRC_SHIFT`, 3: right shift applied to `precursor_neutrons` to form the delayed source term.
- `INIT_FLUX`, 2^47: reset value of `neutron_flux`.
- `SCRAM_COEF`, −2^19: coefficient forced during scram. Exists only with the macro defined.

Ports:
- `clk_in`, input, 1: single clock.
- `rst_in`, input, 1: synchronous, active-high reset.
- `step_en`, input, 1: enables the step period counter.
- `reactivity_coef`, input, 24: signed Q(24−COEF_FRAC_BITS).COEF_FRAC_BITS value equal to (ρ−β)·dt/Λ.
- `precursor_neutrons`, input, 64: unsigned result from the precursor tracker.
- `new_timestep`, output, 1: one-cycle pulse to the trackers.
- `neutron_flux`, output, 51: unsigned flux, registered.
- `step_done`, output, 1: one-cycle pulse when the new flux is visible.
- `step_count`, output, 32: number of completed steps; wraps modulo 2^32.
- `flux_sat`, output, 1: sticky flag; set on any clamp.
- `scram_in`, input, 1: exists only with the macro defined.

## Operation
Period counter `cnt`:
- Increments each cycle while `step_en`=1 and wraps to 0 at CYCLES_PER_STEP−1.
- Holds while `step_en`=0.
- A wrap event moves the FSM from IDLE to ISSUE.

FSM, with the pulse cycle labelled T:
- IDLE → ISSUE on wrap. `new_timestep`=1 during ISSUE (cycle T).
- ISSUE → WAIT (cycle T+1).
- WAIT → SAMPLE (cycle T+2). At the end of SAMPLE:
  - capture `precursor_neutrons`;
  - capture `reactivity_coef`;
  - register product P = coef × {1'b0, flux} (signed, 76 bits).
- SAMPLE → ADD (cycle T+3). At the end of ADD, compute S = flux + (P >>> COEF_FRAC_BITS) + (precursor >> SRC_SHIFT) as a signed sum of at least 77 bits, then:
  - if S < 0, the flux becomes 0 and `flux_sat` is set;
  - if S > 2^51−1, the flux becomes 2^51−1 and `flux_sat` is set;
  - otherwise the flux becomes S.
- ADD → IDLE. `step_done`=1 during cycle T+4, and `step_count` increments at the same edge.

Flux bus hold rule: `neutron_flux` changes only at the end of ADD. It is therefore stable during T and T+1, which the tracker requires on both of its update edges.

`step_en` falling mid-sequence: the in-flight sequence completes, and no new pulse is issued.

Because CYCLES_PER_STEP ≥ 5, a wrap never occurs outside IDLE. The next pulse comes at the earliest at T+5.

## Timing
- Reset values:
  - `new_timestep`=0, `neutron_flux`=INIT_FLUX, `step_done`=0, `step_count`=0, `flux_sat`=0;
  - `cnt`=0, FSM=IDLE, scram latch=0.
- With `step_en` held at 1 from the first post-reset cycle (cycle 0), pulses occur in cycles CYCLES_PER_STEP, 2·CYCLES_PER_STEP, and so on.
- Pulse to visible flux: 4 cycles (visible in T+4, coincident with `step_done`).
- `rst_in` asserted in any state aborts the step. All outputs show reset values in the following cycle, and no `step_done` is emitted.
- `reactivity_coef` and `precursor_neutrons` are sampled only at the end of SAMPLE and are don't-care otherwise.

## Configuration
- `KINETICS_SCRAM_EN` defined:
  - adds the `scram_in` port and the `SCRAM_COEF` parameter;
  - `scram_in`=1 in any cycle sets a sticky scram latch, cleared only by reset;
  - while the latch is set, SAMPLE uses SCRAM_COEF in place of `reactivity_coef`;
  - a scram arriving during ADD applies from the next step.
- `KINETICS_SCRAM_EN` undefined: no port, no latch, and `reactivity_coef` is always used.

## Test plan
All scenarios use the default parameters.
- Cadence: with `step_en`=1, `new_timestep` is high in exactly cycles 16, 32 and 48, one cycle wide, and `step_done` is high in cycles 20, 36 and 52. Dropping `step_en` in cycle 17 suppresses the cycle-32 pulse while `step_done` still fires in cycle 20.
- Equilibrium: coef=−2^20 (−1.0), precursor=2^50 → the flux stays at 2^47 for 10 steps, `flux_sat`=0 and `step_count`=10.
- Growth and upper clamp: coef=+2^20, precursor=0 → the flux goes 2^48, 2^49, 2^50, then 2^51−1 on step 4, with `flux_sat`=1 from cycle T+4 of step 4.
- Lower clamp: coef=−2^21, precursor=0 → the flux is 0 after step 1 and `flux_sat`=1. Setting coef=0 and precursor=2^10 then gives a flux of 2^7 after step 2, with `flux_sat` still 1.
- Bus stability and reset: the flux is unchanged across T and T+1 in every step. `rst_in` asserted in cycle T+2 gives a flux of 2^47 and FSM=IDLE in T+3, with no `step_done`.
- Scram (macro defined): coef=0, precursor=0, pulse `scram_in` before a step → the flux after that step is 2^47 − 2^46 = 2^46, and the latch persists after `scram_in` is released.
